// File: rtl/pwm_dual_motors_pkg.sv
// Shared definitions for the dual-motor PWM bridge driver.
// Holds the one-hot direction codes, the per-side command encoding, the per-side FSM
// state encoding and the bridge pin encoding helper.
package pwm_dual_motors_pkg;

  // One-hot direction command from the upstream decoder.
  localparam logic [4:0] FORWARD  = 5'b00001;
  localparam logic [4:0] BACKWARD = 5'b00010;
  localparam logic [4:0] LEFT     = 5'b00100;
  localparam logic [4:0] RIGHT    = 5'b01000;
  localparam logic [4:0] STOP     = 5'b10000;

  // Per-side motor command.
  typedef enum logic [1:0] {
    CMD_OFF = 2'd0,
    CMD_FWD = 2'd1,
    CMD_REV = 2'd2
  } side_cmd_e;

  // Per-side FSM state; StOff must stay at zero so reset lands in it.
  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StFwd  = 2'd1,
    StRev  = 2'd2,
    StDead = 2'd3
  } motor_state_e;

  // Bridge pins {hi, lo}: forward drives lo, reverse drives hi, everything else floats low.
  function automatic logic [1:0] pin_enc(motor_state_e s);
    logic [1:0] p;
    p = 2'b00;
    if (s == StFwd) begin
      p = 2'b01;
    end else if (s == StRev) begin
      p = 2'b10;
    end
    return p;
  endfunction

endpackage

// File: rtl/pwm_dual_motors_motor_channel.sv
// One bridge side: direction FSM with reversal dead-time, duty ramp and registered pins.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   cmd_i      per-side command (off / forward / reverse)
//   speed_i    target duty, only looked at on wrap_i
//   wrap_i     last clock of a PWM period
//   pwm_cnt_i  shared PWM counter
//   pins_o     bridge inputs {hi, lo}
//   en_o       PWM enable
//   dead_o     high while the side sits in dead-time
module motor_channel
  import pwm_dual_motors_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEAD_CYCLES = 125000,
  parameter int unsigned RAMP_STEP   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  side_cmd_e           cmd_i,
  input  logic [PWM_BITS-1:0] speed_i,
  input  logic                wrap_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic [1:0]          pins_o,
  output logic                en_o,
  output logic                dead_o
);

  localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned SumW  = PWM_BITS + 2;
  localparam logic [DeadW-1:0]    DeadLoad = DeadW'(DEAD_CYCLES - 1);
  localparam logic [SumW-1:0]     StepW    = SumW'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] StepN    = PWM_BITS'(RAMP_STEP);

  motor_state_e        state_q, state_d;
  motor_state_e        pending_q, pending_d;
  motor_state_e        cmd_state;
  logic [DeadW-1:0]    dead_cnt_q, dead_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] ramped;
  logic [PWM_BITS-1:0] dn_n;
  logic [SumW-1:0]     duty_w, speed_w, up_w;
  logic [1:0]          pins_q;
  logic                en_q, dead_q;

  always_comb begin
    cmd_state = StOff;
    if (cmd_i == CMD_FWD) begin
      cmd_state = StFwd;
    end else if (cmd_i == CMD_REV) begin
      cmd_state = StRev;
    end
  end

  // Ramp math is done wider than the duty so a step can never wrap past 0 or full scale.
  assign duty_w  = SumW'(duty_q);
  assign speed_w = SumW'(speed_i);
  assign up_w    = duty_w + StepW;
  assign dn_n    = duty_q - StepN;

  always_comb begin
    ramped = duty_q;
    if (duty_w < speed_w) begin
      ramped = (up_w > speed_w) ? speed_i : up_w[PWM_BITS-1:0];
    end else if (duty_w > speed_w) begin
      // dn_n is only taken when duty >= speed + step, so it cannot underflow.
      ramped = (duty_w < speed_w + StepW) ? speed_i : dn_n;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    dead_cnt_d = dead_cnt_q;
    duty_d     = duty_q;
    unique case (state_q)
      StOff: begin
        if (cmd_state != StOff) begin
          state_d = cmd_state;
          duty_d  = '0;
        end
      end
      StFwd, StRev: begin
        if (cmd_state == StOff) begin
          state_d = StOff;
          duty_d  = '0;
        end else if (cmd_state == state_q) begin
          if (wrap_i) begin
            duty_d = ramped;
          end
        end else begin
          state_d    = StDead;
          pending_d  = cmd_state;
          dead_cnt_d = DeadLoad;
          duty_d     = '0;
        end
      end
      StDead: begin
        if (cmd_state == StOff) begin
          state_d = StOff;
          duty_d  = '0;
        end else if (cmd_state != pending_q) begin
          // Reversed again mid dead-time: restart the full interval.
          pending_d  = cmd_state;
          dead_cnt_d = DeadLoad;
        end else if (dead_cnt_q == '0) begin
          state_d = pending_q;
          duty_d  = '0;
        end else begin
          dead_cnt_d = dead_cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StOff;
      pending_q  <= StOff;
      dead_cnt_q <= '0;
      duty_q     <= '0;
      pins_q     <= 2'b00;
      en_q       <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      dead_cnt_q <= dead_cnt_d;
      duty_q     <= duty_d;
      // Pins follow the registered state, giving a two-edge command-to-pin latency.
      pins_q     <= pin_enc(state_q);
      en_q       <= ((state_q == StFwd) || (state_q == StRev)) && (pwm_cnt_i < duty_q);
      dead_q     <= (state_q == StDead);
    end
  end

  assign pins_o = pins_q;
  assign en_o   = en_q;
  assign dead_o = dead_q;

endmodule

// File: rtl/pwm_dual_motors.sv
// Dual H-bridge driver with PWM speed, duty ramping, reversal dead-time and turn modes.
// Ports:
//   clk_125mhz  system clock
//   reset       synchronous active-high reset
//   direction   one-hot command: FWD, BWD, LEFT, RIGHT, STOP
//   speed       target duty for both sides
//   in[4:1]     bridge inputs, side A = in[2:1], side B = in[4:3]
//   en[2:1]     PWM enables, en[1] side A, en[2] side B
//   dead[2:1]   per-side dead-time indicator
module pwm_dual_motors
  import pwm_dual_motors_pkg::*;
#(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PWM_PRESCALE = 49,
  parameter int unsigned DEAD_CYCLES  = 125000,
  parameter int unsigned RAMP_STEP    = 4,
  parameter int unsigned TURN_MODE    = 0
) (
  input  logic                clk_125mhz,
  input  logic                reset,
  input  logic [4:0]          direction,
  input  logic [PWM_BITS-1:0] speed,
  output logic [4:1]          in,
  output logic [2:1]          en,
  output logic [2:1]          dead
);

  localparam int unsigned PresW = (PWM_PRESCALE > 0) ? $clog2(PWM_PRESCALE + 1) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(PWM_PRESCALE);

  logic [PresW-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick, wrap;
  side_cmd_e           cmd_a, cmd_b;
  logic [1:0]          pins_a, pins_b;
  logic                en_a, en_b, dead_a, dead_b;

  assign tick      = (presc_q == PresMax);
  assign presc_d   = tick ? '0 : presc_q + 1'b1;
  assign pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
  assign wrap      = tick && (&pwm_cnt_q);

  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Non-one-hot and zero commands fall through to both sides off.
  always_comb begin
    cmd_a = CMD_OFF;
    cmd_b = CMD_OFF;
    unique case (direction)
      FORWARD: begin
        cmd_a = CMD_FWD;
        cmd_b = CMD_FWD;
      end
      BACKWARD: begin
        cmd_a = CMD_REV;
        cmd_b = CMD_REV;
      end
      LEFT: begin
        cmd_a = (TURN_MODE != 0) ? CMD_REV : CMD_OFF;
        cmd_b = CMD_FWD;
      end
      RIGHT: begin
        cmd_a = CMD_FWD;
        cmd_b = (TURN_MODE != 0) ? CMD_REV : CMD_OFF;
      end
      default: begin
        cmd_a = CMD_OFF;
        cmd_b = CMD_OFF;
      end
    endcase
  end

  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEAD_CYCLES (DEAD_CYCLES),
    .RAMP_STEP   (RAMP_STEP)
  ) u_side_a (
    .clk_i     (clk_125mhz),
    .rst_i     (reset),
    .cmd_i     (cmd_a),
    .speed_i   (speed),
    .wrap_i    (wrap),
    .pwm_cnt_i (pwm_cnt_q),
    .pins_o    (pins_a),
    .en_o      (en_a),
    .dead_o    (dead_a)
  );

  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEAD_CYCLES (DEAD_CYCLES),
    .RAMP_STEP   (RAMP_STEP)
  ) u_side_b (
    .clk_i     (clk_125mhz),
    .rst_i     (reset),
    .cmd_i     (cmd_b),
    .speed_i   (speed),
    .wrap_i    (wrap),
    .pwm_cnt_i (pwm_cnt_q),
    .pins_o    (pins_b),
    .en_o      (en_b),
    .dead_o    (dead_b)
  );

  assign in   = {pins_b, pins_a};
  assign en   = {en_b, en_a};
  assign dead = {dead_b, dead_a};

endmodule
